// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Write strobes go into a small FIFO, and each byte is sent LSB first on tx.
// A write at edge E0 into an idle block drives the start bit from E1. Writes into a full FIFO are dropped and raise a one-cycle overflow flag.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrsig,
    input  logic [7:0] datain,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [2:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity;
    logic          bit_end;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    assign head    = mem[rd_ptr];
    assign bit_end = (clk_cnt == CLK_LAST);
    assign full    = (count == CNT_FULL);
    assign busy    = (state != ST_IDLE) || (count != '0);
    // Full is judged before any pop, so a write that arrives with a pop in the same cycle into a full FIFO is still lost.
    assign push    = wrsig && !full;
    assign pop     = (count != '0) && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= datain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wrsig && full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            parity  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state   <= ST_START;
                        tx      <= 1'b0;
                        shift   <= head;
                        parity  <= (^head) ^ PARITY_ODD;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        tx      <= shift[0];
                        clk_cnt <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        shift   <= shift >> 1;
                        if (bit_cnt == 3'd7) begin
                            if (PARITY_EN) begin
                                state <= ST_PARITY;
                                tx    <= parity;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tx <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state   <= ST_STOP;
                        tx      <= 1'b1;
                        clk_cnt <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        // Chain straight into the next start bit so queued bytes leave with no idle gap.
                        if (pop) begin
                            state   <= ST_START;
                            tx      <= 1'b0;
                            shift   <= head;
                            parity  <= (^head) ^ PARITY_ODD;
                            bit_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. A queue-and-frame-position model checks the default instance on every cycle.
// Directed literals fix single-frame timing, the overflow and full points, parity values and reset behaviour.
module tb_uart_tx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FL    = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr0 = 1'b0;
    logic [7:0] din0 = 8'h00;
    logic       wr_p = 1'b0;
    logic [7:0] din_p = 8'h00;
    logic       tx0, busy0, full0, ovf0;
    logic       tx1, busy1, full1, ovf1;
    logic       tx2, busy2, full2, ovf2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .wrsig(wr0), .datain(din0),
        .tx(tx0), .busy(busy0), .full(full0), .overflow(ovf0));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .rst(rst), .wrsig(wr_p), .datain(din_p),
        .tx(tx1), .busy(busy1), .full(full1), .overflow(ovf1));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
        .clk(clk), .rst(rst), .wrsig(wr_p), .datain(din_p),
        .tx(tx2), .busy(busy2), .full(full2), .overflow(ovf2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes waiting in the queue, plus the byte currently on the wire and how far into its frame it is.
    logic [7:0] mq[$];
    logic       m_act = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         m_pos = 0;
    logic       m_ovf = 1'b0;

    initial forever begin
        logic was_full;
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_act = 1'b0;
            m_pos = 0;
            m_ovf = 1'b0;
        end else begin
            was_full = (mq.size() == DEPTH);
            m_ovf = wr0 && was_full;
            if (m_act) begin
                if (m_pos == FL - 1) begin
                    if (mq.size() != 0) begin
                        m_byte = mq.pop_front();
                        m_pos  = 0;
                    end else begin
                        m_act = 1'b0;
                    end
                end else begin
                    m_pos++;
                end
            end else if (mq.size() != 0) begin
                m_byte = mq.pop_front();
                m_pos  = 0;
                m_act  = 1'b1;
            end
            if (wr0 && !was_full) mq.push_back(din0);
        end
    end

    function automatic logic exp_tx();
        int slot;
        if (!m_act) return 1'b1;
        slot = m_pos / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_byte[slot-1];
        return 1'b1;
    endfunction

    logic full_seen = 1'b0;
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("model_tx", {31'd0, tx0}, {31'd0, exp_tx()});
            check("model_busy", {31'd0, busy0}, {31'd0, m_act || (mq.size() != 0)});
            check("model_full", {31'd0, full0}, {31'd0, mq.size() == DEPTH});
            check("model_ovf", {31'd0, ovf0}, {31'd0, m_ovf});
            if (full0) full_seen = 1'b1;
        end
    end

    // Line decoder: samples each bit at its centre and collects the received bytes.
    logic [7:0] rx[$];
    logic [7:0] rx_b;
    initial forever begin
        @(negedge clk);
        if (!rst && tx0 === 1'b0) begin
            repeat (CPB / 2 - 1) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                rx_b[k] = tx0;
            end
            repeat (CPB) @(negedge clk);
            rx.push_back(rx_b);
        end
    end

    task automatic check_rx(input string name, input logic [7:0] exp_bytes[$]);
        check({name, "_count"}, rx.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < rx.size(); i++)
            check({name, "_byte"}, {24'd0, rx[i]}, {24'd0, exp_bytes[i]});
        rx.delete();
    endtask

    logic [7:0] exp_q[$];
    logic [9:0] slot_exp;
    string      hello;
    int         nonidle;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", {31'd0, tx0}, 32'd1);
        check("reset_busy", {31'd0, busy0}, 32'd0);
        check("reset_full", {31'd0, full0}, 32'd0);
        check("reset_ovf", {31'd0, ovf0}, 32'd0);

        // Single byte 0x48: start, LSB-first data 0,0,0,1,0,0,1,0, stop.
        slot_exp = 10'b1_0100_1000_0;
        wr0 = 1'b1; din0 = 8'h48;
        @(negedge clk);
        wr0 = 1'b0;
        repeat (9) @(negedge clk);
        for (int s = 0; s < 10; s++) begin
            check("h48_slot", {31'd0, tx0}, {31'd0, slot_exp[s]});
            if (s < 9) repeat (16) @(negedge clk);
        end
        repeat (7) @(negedge clk);
        check("h48_busy_last", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        check("h48_busy_done", {31'd0, busy0}, 32'd0);
        exp_q = '{8'h48};
        check_rx("h48_rx", exp_q);

        // Six back-to-back writes: the sixth hits a full FIFO.
        for (int i = 0; i < 6; i++) begin
            wr0 = 1'b1; din0 = 8'(i + 1);
            @(negedge clk);
            if (i == 4) check("burst_full", {31'd0, full0}, 32'd1);
            if (i == 5) check("burst_ovf", {31'd0, ovf0}, 32'd1);
        end
        wr0 = 1'b0;
        @(negedge clk);
        check("burst_ovf_pulse", {31'd0, ovf0}, 32'd0);
        repeat (794) @(negedge clk);
        check("burst_busy_last", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        check("burst_busy_done", {31'd0, busy0}, 32'd0);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_rx("burst_rx", exp_q);

        // Push coincides with the STOP-to-START pop while three bytes are queued.
        for (int i = 0; i < 4; i++) begin
            wr0 = 1'b1; din0 = 8'hA1 + 8'(i);
            @(negedge clk);
        end
        wr0 = 1'b0;
        repeat (157) @(negedge clk);
        wr0 = 1'b1; din0 = 8'hA5;
        @(negedge clk);
        wr0 = 1'b0;
        check("pushpop_ovf", {31'd0, ovf0}, 32'd0);
        check("pushpop_full", {31'd0, full0}, 32'd0);
        repeat (640) @(negedge clk);
        check("pushpop_busy_done", {31'd0, busy0}, 32'd0);
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        check_rx("pushpop_rx", exp_q);

        // Parity: 0x07 has three ones, so even parity gives 1 and odd parity gives 0.
        wr_p = 1'b1; din_p = 8'h07;
        @(negedge clk);
        wr_p = 1'b0;
        repeat (9) @(negedge clk);
        check("par_start_even", {31'd0, tx1}, 32'd0);
        check("par_start_odd", {31'd0, tx2}, 32'd0);
        repeat (144) @(negedge clk);
        check("par_bit_even", {31'd0, tx1}, 32'd1);
        check("par_bit_odd", {31'd0, tx2}, 32'd0);
        repeat (16) @(negedge clk);
        check("par_stop_even", {31'd0, tx1}, 32'd1);
        check("par_stop_odd", {31'd0, tx2}, 32'd1);
        repeat (7) @(negedge clk);
        check("par_busy_last", {31'd0, busy1}, 32'd1);
        @(negedge clk);
        check("par_busy_done_even", {31'd0, busy1}, 32'd0);
        check("par_busy_done_odd", {31'd0, busy2}, 32'd0);
        check("par_flags", {30'd0, full1 | full2, ovf1 | ovf2}, 32'd0);

        // Reset in mid-frame with two bytes queued.
        for (int i = 0; i < 3; i++) begin
            wr0 = 1'b1; din0 = 8'hC0 + 8'(i);
            @(negedge clk);
        end
        wr0 = 1'b0;
        repeat (47) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_tx", {31'd0, tx0}, 32'd1);
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_full", {31'd0, full0}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nonidle = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) nonidle++;
        end
        check("midrst_quiet", nonidle, 0);
        rx.delete();

        // Text stream at the upstream strobe spacing.
        hello = "Hello NEXYS 4 DDR\n\r";
        full_seen = 1'b0;
        exp_q.delete();
        for (int i = 0; i < hello.len(); i++) begin
            wr0 = 1'b1; din0 = hello[i];
            exp_q.push_back(hello[i]);
            @(negedge clk);
            wr0 = 1'b0;
            repeat (254) @(negedge clk);
        end
        repeat (100) @(negedge clk);
        check("stream_full_never", {31'd0, full_seen}, 32'd0);
        check_rx("stream_rx", exp_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
